register_rename_unit: RTL and testbench

//  Parametrised rename stage between decode and the active list. It maps logical
//   rs/rt/rw to physical tags and allocates a new physical rw from a bit-vector free list.
//  It keeps a speculative map and a committed (retirement) map. Commit releases the

---
 rtl/mips_core_pkg.sv | 19 +
 rtl/priority_encoder.sv | 33 +++
 rtl/register_rename_unit.sv | 184 ++++++++++++++++++
 tb/tb_register_rename_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core definitions used by the rename stage.
package mips_core_pkg;

  localparam int unsigned NUM_LOG_REGS_DEFAULT  = 32;
  localparam int unsigned NUM_PHYS_REGS_DEFAULT = 64;
  localparam int unsigned DEF_LOG_W             = $clog2(NUM_LOG_REGS_DEFAULT);
  localparam int unsigned DEF_PHYS_W            = $clog2(NUM_PHYS_REGS_DEFAULT);

  typedef logic [DEF_LOG_W-1:0]  LogReg;
  typedef logic [DEF_PHYS_W-1:0] PhysReg;

  // Retirement payload from the active list
  typedef struct packed {
    LogReg  log;
    PhysReg phys;
    PhysReg prev;
  } RenameCommit;

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder; HIGH_PRIORITY=0 selects the lowest set index.
module priority_encoder #(
  parameter int unsigned  NUM_OF_INPUTS = 8,
  parameter bit           HIGH_PRIORITY = 1'b0,
  localparam int unsigned IDX_W = (NUM_OF_INPUTS > 1) ? $clog2(NUM_OF_INPUTS) : 1
) (
  input  logic [NUM_OF_INPUTS-1:0] req_i,
  output logic [IDX_W-1:0]         idx_c,
  output logic                     valid_c
);

  // Scan so that the winning request is the last one written
  always_comb begin
    idx_c   = '0;
    valid_c = 1'b0;
    if (HIGH_PRIORITY == 1'b0) begin
      for (int i = int'(NUM_OF_INPUTS) - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          idx_c   = IDX_W'(i);
          valid_c = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < int'(NUM_OF_INPUTS); i++) begin
        if (req_i[i]) begin
          idx_c   = IDX_W'(i);
          valid_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/register_rename_unit.sv
// Rename stage: speculative/committed map tables, bit-vector free list, registered output.
module register_rename_unit
  import mips_core_pkg::*;
#(
  parameter int unsigned  NUM_LOG_REGS  = NUM_LOG_REGS_DEFAULT,
  parameter int unsigned  NUM_PHYS_REGS = NUM_PHYS_REGS_DEFAULT,
  localparam int unsigned LOG_W         = $clog2(NUM_LOG_REGS),
  localparam int unsigned PHYS_W        = $clog2(NUM_PHYS_REGS),
  localparam int unsigned CNT_W         = PHYS_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_uses_rs,
  input  logic              in_uses_rt,
  input  logic              in_uses_rw,
  input  logic [LOG_W-1:0]  in_rs,
  input  logic [LOG_W-1:0]  in_rt,
  input  logic [LOG_W-1:0]  in_rw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_uses_rs,
  output logic              out_uses_rt,
  output logic              out_uses_rw,
  output logic [PHYS_W-1:0] out_rs,
  output logic [PHYS_W-1:0] out_rt,
  output logic [PHYS_W-1:0] out_rw,
  output logic [PHYS_W-1:0] out_prev_rw,
  output logic [LOG_W-1:0]  out_log_rw,
  input  logic              commit_valid,
  input  logic [LOG_W-1:0]  commit_log,
  input  logic [PHYS_W-1:0] commit_phys,
  input  logic [PHYS_W-1:0] commit_prev,
  input  logic              flush,
  output logic [CNT_W-1:0]  free_count
);

  localparam logic [NUM_PHYS_REGS-1:0] RESET_FREE =
    {{(NUM_PHYS_REGS-NUM_LOG_REGS){1'b1}}, {NUM_LOG_REGS{1'b0}}};

  logic [PHYS_W-1:0]        spec_map_q   [NUM_LOG_REGS];
  logic [PHYS_W-1:0]        spec_map_d   [NUM_LOG_REGS];
  logic [PHYS_W-1:0]        commit_map_q [NUM_LOG_REGS];
  logic [PHYS_W-1:0]        commit_map_d [NUM_LOG_REGS];
  logic [NUM_PHYS_REGS-1:0] free_q, free_d, used_c;
  logic [CNT_W-1:0]         free_count_q, free_count_d;

  logic              out_valid_q, out_valid_d;
  logic              out_uses_rs_q, out_uses_rs_d;
  logic              out_uses_rt_q, out_uses_rt_d;
  logic              out_uses_rw_q, out_uses_rw_d;
  logic [PHYS_W-1:0] out_rs_q, out_rs_d;
  logic [PHYS_W-1:0] out_rt_q, out_rt_d;
  logic [PHYS_W-1:0] out_rw_q, out_rw_d;
  logic [PHYS_W-1:0] out_prev_rw_q, out_prev_rw_d;
  logic [LOG_W-1:0]  out_log_rw_q, out_log_rw_d;

  logic              alloc_c, accept_c, release_c, tag_valid_c;
  logic [PHYS_W-1:0] alloc_tag_c;

  // Lowest-index free physical register
  priority_encoder #(
    .NUM_OF_INPUTS (NUM_PHYS_REGS),
    .HIGH_PRIORITY (1'b0)
  ) u_free_pick (
    .req_i   (free_q),
    .idx_c   (alloc_tag_c),
    .valid_c (tag_valid_c)
  );

  // Handshake: writers stall only when the free list is empty
  always_comb begin
    alloc_c   = in_uses_rw && (in_rw != '0);
    in_ready  = !flush && (!out_valid_q || out_ready) && (!alloc_c || (free_count_q != '0));
    accept_c  = in_valid && in_ready;
    release_c = commit_valid && (commit_prev != '0);
  end

  // Next state for maps, free list, counter and output register
  always_comb begin
    spec_map_d    = spec_map_q;
    commit_map_d  = commit_map_q;
    free_d        = free_q;
    used_c        = '0;
    out_valid_d   = out_valid_q;
    out_uses_rs_d = out_uses_rs_q;
    out_uses_rt_d = out_uses_rt_q;
    out_uses_rw_d = out_uses_rw_q;
    out_rs_d      = out_rs_q;
    out_rt_d      = out_rt_q;
    out_rw_d      = out_rw_q;
    out_prev_rw_d = out_prev_rw_q;
    out_log_rw_d  = out_log_rw_q;

    if (commit_valid) commit_map_d[commit_log] = commit_phys;
    if (release_c)    free_d[commit_prev] = 1'b1;

    if (accept_c) begin
      out_valid_d   = 1'b1;
      out_uses_rs_d = in_uses_rs;
      out_uses_rt_d = in_uses_rt;
      out_uses_rw_d = in_uses_rw;
      out_rs_d      = in_uses_rs ? spec_map_q[in_rs] : '0;
      out_rt_d      = in_uses_rt ? spec_map_q[in_rt] : '0;
      out_rw_d      = alloc_c ? alloc_tag_c : '0;
      out_prev_rw_d = alloc_c ? spec_map_q[in_rw] : '0;
      out_log_rw_d  = in_rw;
      if (alloc_c) begin
        spec_map_d[in_rw]   = alloc_tag_c;
        free_d[alloc_tag_c] = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    free_count_d = free_count_q + CNT_W'(release_c) - CNT_W'(accept_c && alloc_c);

    // Rollback: anything the retirement map does not reference is free again
    if (flush) begin
      for (int unsigned i = 0; i < NUM_LOG_REGS; i++) used_c[commit_map_d[i]] = 1'b1;
      free_d      = ~used_c;
      free_d[0]   = 1'b0;
      spec_map_d  = commit_map_d;
      out_valid_d = 1'b0;
      free_count_d = '0;
      for (int unsigned p = 0; p < NUM_PHYS_REGS; p++) begin
        free_count_d = free_count_d + CNT_W'(free_d[p]);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_LOG_REGS; i++) begin
        spec_map_q[i]   <= PHYS_W'(i);
        commit_map_q[i] <= PHYS_W'(i);
      end
      free_q        <= RESET_FREE;
      free_count_q  <= CNT_W'(NUM_PHYS_REGS - NUM_LOG_REGS);
      out_valid_q   <= 1'b0;
      out_uses_rs_q <= 1'b0;
      out_uses_rt_q <= 1'b0;
      out_uses_rw_q <= 1'b0;
      out_rs_q      <= '0;
      out_rt_q      <= '0;
      out_rw_q      <= '0;
      out_prev_rw_q <= '0;
      out_log_rw_q  <= '0;
    end else begin
      spec_map_q    <= spec_map_d;
      commit_map_q  <= commit_map_d;
      free_q        <= free_d;
      free_count_q  <= free_count_d;
      out_valid_q   <= out_valid_d;
      out_uses_rs_q <= out_uses_rs_d;
      out_uses_rt_q <= out_uses_rt_d;
      out_uses_rw_q <= out_uses_rw_d;
      out_rs_q      <= out_rs_d;
      out_rt_q      <= out_rt_d;
      out_rw_q      <= out_rw_d;
      out_prev_rw_q <= out_prev_rw_d;
      out_log_rw_q  <= out_log_rw_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_uses_rs = out_uses_rs_q;
  assign out_uses_rt = out_uses_rt_q;
  assign out_uses_rw = out_uses_rw_q;
  assign out_rs      = out_rs_q;
  assign out_rt      = out_rt_q;
  assign out_rw      = out_rw_q;
  assign out_prev_rw = out_prev_rw_q;
  assign out_log_rw  = out_log_rw_q;
  assign free_count  = free_count_q;

  // Counter tracks the vector; tag 0 is never free; a nonzero count always yields a tag
  a_free_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (CNT_W'($countones(free_q)) == free_count_q) && !free_q[0] &&
    ((free_count_q == '0) || tag_valid_c));

endmodule

// File: tb/tb_register_rename_unit.sv
// Bench for register_rename_unit: reference model plus directed scenarios.
module tb_register_rename_unit;

  localparam int unsigned NL = 32;
  localparam int unsigned NP = 64;
  localparam int unsigned LW = 5;
  localparam int unsigned PW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, in_uses_rs, in_uses_rt, in_uses_rw;
  logic [LW-1:0] in_rs, in_rt, in_rw;
  logic          out_valid, out_ready, out_uses_rs, out_uses_rt, out_uses_rw;
  logic [PW-1:0] out_rs, out_rt, out_rw, out_prev_rw;
  logic [LW-1:0] out_log_rw;
  logic          commit_valid;
  logic [LW-1:0] commit_log;
  logic [PW-1:0] commit_phys, commit_prev;
  logic          flush;
  logic [PW:0]   free_count;

  register_rename_unit #(.NUM_LOG_REGS(NL), .NUM_PHYS_REGS(NP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_uses_rw(in_uses_rw),
    .in_rs(in_rs), .in_rt(in_rt), .in_rw(in_rw),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_uses_rs(out_uses_rs), .out_uses_rt(out_uses_rt), .out_uses_rw(out_uses_rw),
    .out_rs(out_rs), .out_rt(out_rt), .out_rw(out_rw),
    .out_prev_rw(out_prev_rw), .out_log_rw(out_log_rw),
    .commit_valid(commit_valid), .commit_log(commit_log),
    .commit_phys(commit_phys), .commit_prev(commit_prev),
    .flush(flush), .free_count(free_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_spec [NL];
  int m_comm [NL];
  bit m_free [NP];
  bit m_ov, m_urs, m_urt, m_urw;
  int m_rs, m_rt, m_rw, m_prev, m_log;

  function automatic int m_nfree();
    int n = 0;
    for (int p = 0; p < int'(NP); p++) if (m_free[p]) n++;
    return n;
  endfunction

  function automatic int m_lowest();
    for (int p = 0; p < int'(NP); p++) if (m_free[p]) return p;
    return 0;
  endfunction

  function automatic bit m_ready();
    bit alloc = in_uses_rw && (in_rw != 0);
    return !flush && (!m_ov || out_ready) && (!alloc || (m_nfree() != 0));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(NL); i++) begin m_spec[i] = i; m_comm[i] = i; end
    for (int p = 0; p < int'(NP); p++) m_free[p] = (p >= int'(NL));
    m_ov = 0; m_urs = 0; m_urt = 0; m_urw = 0;
    m_rs = 0; m_rt = 0; m_rw = 0; m_prev = 0; m_log = 0;
  endtask

  task automatic m_step();
    bit alloc = in_uses_rw && (in_rw != 0);
    bit acc   = in_valid && m_ready();
    int tag   = m_lowest();
    if (flush) m_ov = 0;
    else if (acc) begin
      m_ov = 1; m_urs = in_uses_rs; m_urt = in_uses_rt; m_urw = in_uses_rw;
      m_rs   = in_uses_rs ? m_spec[in_rs] : 0;
      m_rt   = in_uses_rt ? m_spec[in_rt] : 0;
      m_rw   = alloc ? tag : 0;
      m_prev = alloc ? m_spec[in_rw] : 0;
      m_log  = int'(in_rw);
    end else if (out_ready) m_ov = 0;
    if (commit_valid) begin
      m_comm[commit_log] = int'(commit_phys);
      if (commit_prev != 0) m_free[commit_prev] = 1;
    end
    if (acc && alloc) begin m_spec[in_rw] = tag; m_free[tag] = 0; end
    if (flush) begin
      for (int p = 0; p < int'(NP); p++) m_free[p] = (p != 0);
      for (int i = 0; i < int'(NL); i++) begin m_free[m_comm[i]] = 0; m_spec[i] = m_comm[i]; end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  always @(posedge clk) if (rst_n && out_valid && out_ready) xfers++;

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("free_count", 32'(free_count), 32'(m_nfree()));
      if (m_ov) begin
        chk("out_uses_rs", 32'(out_uses_rs), 32'(m_urs));
        chk("out_uses_rt", 32'(out_uses_rt), 32'(m_urt));
        chk("out_uses_rw", 32'(out_uses_rw), 32'(m_urw));
        chk("out_rs", 32'(out_rs), 32'(m_rs));
        chk("out_rt", 32'(out_rt), 32'(m_rt));
        chk("out_rw", 32'(out_rw), 32'(m_rw));
        chk("out_prev_rw", 32'(out_prev_rw), 32'(m_prev));
        chk("out_log_rw", 32'(out_log_rw), 32'(m_log));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    in_valid = 0; in_uses_rs = 0; in_uses_rt = 0; in_uses_rw = 0;
    in_rs = '0; in_rt = '0; in_rw = '0; out_ready = 1;
    commit_valid = 0; commit_log = '0; commit_phys = '0; commit_prev = '0; flush = 0;
  endtask

  task automatic ren(input bit urs, input int rs, input bit urw, input int rw);
    in_valid = 1; in_uses_rs = urs; in_rs = LW'(rs);
    in_uses_rt = 0; in_rt = '0; in_uses_rw = urw; in_rw = LW'(rw);
  endtask

  task automatic commit(input int lg, input int ph, input int pv);
    commit_valid = 1; commit_log = LW'(lg); commit_phys = PW'(ph); commit_prev = PW'(pv);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  int x0;

  initial begin
    idle();
    step(2);
    rst_n = 1; cmp_en = 1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_free_count", 32'(free_count), 32);
    chk("rst_out_rw", 32'(out_rw), 0);

    // rename rw=5 with rs=5: source sees the old mapping
    ren(1, 5, 1, 5); #1 chk("t1_in_ready", 32'(in_ready), 1);
    step(1);
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_out_rw", 32'(out_rw), 32);
    chk("t1_out_prev_rw", 32'(out_prev_rw), 5);
    chk("t1_out_rs", 32'(out_rs), 5);
    chk("t1_free_count", 32'(free_count), 31);

    // back-to-back reader sees the new mapping
    ren(1, 5, 0, 0); step(1);
    chk("t2_out_rs", 32'(out_rs), 32);
    chk("t2_out_rw", 32'(out_rw), 0);
    in_valid = 0; step(1);
    chk("t2_drain", 32'(out_valid), 0);

    // drain the free list: rw=1..31 take tags 33..63
    for (int i = 0; i < 31; i++) begin ren(0, 0, 1, i + 1); step(1); end
    chk("t3_last_tag", 32'(out_rw), 63);
    chk("t3_empty", 32'(free_count), 0);
    ren(0, 0, 1, 9); #1 chk("t3_writer_stall", 32'(in_ready), 0);
    step(1);
    chk("t3_stalled_no_out", 32'(out_valid), 0);
    ren(1, 1, 0, 0); #1 chk("t3_reader_ready", 32'(in_ready), 1);
    step(1);
    chk("t3_reader_out_rs", 32'(out_rs), 33);
    ren(0, 0, 1, 9); commit(7, 39, 7); #1 chk("t3_no_bypass", 32'(in_ready), 0);
    step(1);
    chk("t3_released_count", 32'(free_count), 1);
    commit_valid = 0; #1 chk("t3_ready_after_release", 32'(in_ready), 1);
    step(1);
    chk("t3_reused_tag", 32'(out_rw), 7);
    chk("t3_prev_rw9", 32'(out_prev_rw), 41);
    chk("t3_full_again", 32'(free_count), 0);

    // back-pressure: outputs hold for 3 cycles, then exactly one transfer
    ren(1, 2, 0, 0); step(1);
    chk("t4_out_rs", 32'(out_rs), 34);
    out_ready = 0; ren(1, 3, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("t4_hold_valid", 32'(out_valid), 1);
      chk("t4_hold_rs", 32'(out_rs), 34);
      chk("t4_hold_ready", 32'(in_ready), 0);
    end
    x0 = xfers; in_valid = 0; out_ready = 1; step(2);
    chk("t4_released", 32'(out_valid), 0);
    chk("t4_one_xfer", 32'(xfers - x0), 1);

    // mid-operation async reset
    ren(1, 1, 1, 1); commit(2, 34, 2);
    #1 rst_n = 0; #1;
    chk("t5_async_valid", 32'(out_valid), 0);
    chk("t5_async_count", 32'(free_count), 32);
    idle(); step(1); rst_n = 1;

    // rename rw=3 twice, then commit + flush while a rename is offered
    ren(0, 0, 1, 3); step(1);
    chk("t5_first_rw", 32'(out_rw), 32);
    ren(0, 0, 1, 3); step(1);
    chk("t5_second_rw", 32'(out_rw), 33);
    chk("t5_second_prev", 32'(out_prev_rw), 32);
    ren(0, 0, 1, 4); commit(3, 32, 3); flush = 1;
    #1 chk("t5_flush_blocks", 32'(in_ready), 0);
    step(1);
    chk("t5_flush_valid", 32'(out_valid), 0);
    chk("t5_flush_count", 32'(free_count), 32);  // tags 3 and 33..63
    idle(); ren(1, 3, 1, 3); step(1);
    chk("t5_spec3_restored", 32'(out_rs), 32);
    chk("t5_prev3", 32'(out_prev_rw), 32);
    chk("t5_lowest_is_3", 32'(out_rw), 3);
    ren(0, 0, 1, 4); step(1);
    chk("t5_tag33_free", 32'(out_rw), 33);

    // rw=0 never allocates; commit_prev=0 never frees
    ren(0, 0, 1, 0); commit(0, 0, 0); step(1);
    chk("t6_rw0_out_rw", 32'(out_rw), 0);
    chk("t6_rw0_prev", 32'(out_prev_rw), 0);
    chk("t6_rw0_uses", 32'(out_uses_rw), 1);
    chk("t6_count_same", 32'(free_count), 30);
    idle(); step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
